// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared types and helpers for the run/single-step controller.
//   state_e   - mode FSM encoding (RUN / STEP_IDLE / STEP_FIRE, 2'd3 unused)
//   cnt_width - bits needed to hold values 0..n-1 (minimum 1)
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STEP_IDLE = 2'd1,
    ST_STEP_FIRE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/step_ctrl_btn_debounce.sv
// btn_debounce: synchronise, debounce and rising-edge detect one raw button.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   btn   in  raw asynchronous button level
//   pulse out one-cycle pulse when the debounced level rises
// A level change is accepted after the synchronised input has disagreed with
// the current level for DEBOUNCE_CYCLES+1 consecutive samples; any sample that
// agrees restarts the count, so short glitches never reach the level.
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES + 1);

  logic          sync0, sync1;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync0   <= btn;
      sync1   <= sync0;
      level_q <= level;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Falling level never pulses, so release is silent.
  assign pulse = level & ~level_q;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: run/single-step controller upstream of the mips core.
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   btn_change in  raw button, toggles RUN <-> STEP mode
//   btn_step   in  raw button, fires one core cycle in STEP mode
//   cpu_en     out core advances on clk edges where high
//   mode_step  out 1 while in STEP mode (idle or firing)
//   retired    out count of cpu_en cycles, wraps modulo 2^CNT_W
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_DIV         = 1,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_change,
  input  logic             btn_step,
  output logic             cpu_en,
  output logic             mode_step,
  output logic [CNT_W-1:0] retired
);

  localparam int DW = cnt_width(RUN_DIV);

  logic          chg_p, stp_p;
  state_e        state, state_nxt;
  logic [DW-1:0] div;
  logic          div_hit;
  logic          en_dec;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chg (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_change),
    .pulse (chg_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stp (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_step),
    .pulse (stp_p)
  );

  assign div_hit = (div == DW'(RUN_DIV - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next state: mode change always beats a step request.
  always_comb begin
    state_nxt = ST_RUN;
    case (state)
      ST_RUN:       state_nxt = chg_p ? ST_STEP_IDLE : ST_RUN;
      ST_STEP_IDLE: state_nxt = chg_p ? ST_RUN : (stp_p ? ST_STEP_FIRE : ST_STEP_IDLE);
      ST_STEP_FIRE: state_nxt = chg_p ? ST_RUN : ST_STEP_IDLE;
      default:      state_nxt = ST_RUN;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    en_dec    = 1'b0;
    mode_step = 1'b1;
    case (state)
      ST_RUN: begin
        en_dec    = div_hit;
        mode_step = 1'b0;
      end
      ST_STEP_FIRE: en_dec = 1'b1;
      default:      en_dec = 1'b0;
    endcase
  end

  // Held low during reset so the core cannot advance while it is being cleared.
  assign cpu_en = en_dec & ~rst;

  // Divider only runs in RUN; it restarts from 0 on every RUN entry, so the
  // first enable after entry comes RUN_DIV cycles in.
  always_ff @(posedge clk) begin
    if (rst || state != ST_RUN || chg_p) div <= '0;
    else if (div_hit)                    div <= '0;
    else                                 div <= div + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)         retired <= '0;
    else if (cpu_en) retired <= retired + 1'b1;
  end

endmodule
